arb_rr_bin: RTL and testbench
=============================

Name: arb_rr_bin

Overview:
- Round-robin arbiter that shares one resource between WIDTH requesters.
- Holds a registered grant (valid plus binary index) from selection until the resource acknowledges completion, the requester withdraws, or a timeout fires.
- The one-hot grant vector is produced by an internal bin2oht decoder driven from the registered binary grant.
- Sits in front of any shared datapath that is indexed by a binary select and enabled by a one-hot select.

Parameters:
- WIDTH, 8, number of requesters; must be >= 2 and need not be a power of 2.
- SPLIT, 2, tree split factor passed to bin2oht; must be a power of 2.
- IMPLEMENTATION, 0, implementation select passed to bin2oht.
- TIMEOUT, 0, maximum busy cycles without ack before a forced release; 0 disables the timeout.
- WIDTH_LOG (localparam), $clog2(WIDTH), binary index width.
- TMO_LOG (localparam), $clog2(TIMEOUT+1), timeout counter width (minimum 1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  WIDTH  request per requester, level-sensitive.
- ack  input  1  resource completion; releases the current grant.
- gnt_vld  output  1  a grant is active (registered).
- gnt_bin  output  WIDTH_LOG  granted index (registered); 0 when gnt_vld=0.
- gnt_oht  output  WIDTH  one-hot grant, bin2oht(vld=gnt_vld, bin=gnt_bin); all zero when gnt_vld=0.
- tmo  output  1  single-cycle pulse (registered) on a timeout-forced release.

Behaviour:
- Reset: synchronous and active-high, as already decided. While rst=1, at the next edge:
  - state=IDLE, ptr=0, gnt_vld=0, gnt_bin=0, tmo=0, timeout counter=0.
  - gnt_oht therefore reads 0.
  - rst overrides all other inputs, including mid-grant; no release event or tmo is generated.
- Priority:
  - Search starts at ptr and proceeds upward with wrap-around at WIDTH-1 -> 0.
  - ptr holds the index directly after the last released grant, so the last granted requester has lowest priority.
  - Wrap is modulo WIDTH, not 2**WIDTH_LOG: if the last grant was WIDTH-1, ptr=0.
- States (state type from package): IDLE, BUSY.
- IDLE:
  - If |req, latch winner into gnt_bin, set gnt_vld=1 and go to BUSY; latency is 1 cycle from req to grant.
  - Otherwise stay in IDLE.
  - ack in IDLE is ignored.
- BUSY:
  - Release when any of the following hold:
    - ack=1;
    - req[gnt_bin]=0 (withdrawal);
    - TIMEOUT!=0 and counter==TIMEOUT-1.
  - Multiple release causes in the same cycle count as one release. tmo pulses only when ack=0 and req[gnt_bin]=1.
  - On release: ptr <= (gnt_bin==WIDTH-1) ? 0 : gnt_bin+1.
  - The same edge re-arbitrates using the updated ptr and a request vector in which the released requester's bit is masked only if it withdrew.
  - Any remaining request gives a back-to-back grant with no bubble; if none remain, clear gnt_vld and go to IDLE.
  - If the only requester is the one just released and it still requests (ack or timeout case), it is granted again.
  - Without release: hold gnt_bin and increment the counter. The counter clears on every new grant and never wraps.
- Requests arriving or dropping for non-granted indices while BUSY have no effect until the next arbitration.

Decomposition:
- Package arb_pkg holds the state enum typedef (arb_state_t: IDLE, BUSY).
- Sub-module arb_rr_pick: combinational rotated priority encoder.
  - Inputs: req, ptr.
  - Outputs: any, idx (binary).
  - Implemented as masked/unmasked two-pass first-one search, valid for non-power-of-2 WIDTH.
- One bin2oht instance (WIDTH, SPLIT, IMPLEMENTATION) generates gnt_oht from the registered gnt_vld/gnt_bin.

Test Plan:
1. Reset: WIDTH=5, req=5'b11111 held during rst=1 -> gnt_vld=0, gnt_oht=0, tmo=0. First cycle after rst falls: gnt_bin=0, gnt_oht=5'b00001.
2. Rotation with wrap: WIDTH=5, req=5'b11111 constant, ack=1 every BUSY cycle -> gnt_bin sequence 0,1,2,3,4,0 on consecutive cycles with no gnt_vld gaps.
3. Withdrawal: grant on 2, req=5'b00100 -> 5'b01000 -> gnt_bin=3 one cycle later, ptr=3. Then req drop with no others -> gnt_vld=0, IDLE.
4. Timeout: TIMEOUT=4, req=5'b00010, ack=0 -> tmo=1 exactly 4 cycles after grant, then gnt_bin=1 re-granted immediately with counter restarted.
5. Simultaneous ack and withdrawal with TIMEOUT hit on the same cycle -> single release, tmo=0, ptr advances by one only.
6. Mid-grant reset: BUSY on index 3, rst=1 for 1 cycle with ack=1 -> gnt_vld=0, ptr=0. Next grant with req=5'b11000 is index 3.

Source files
------------

// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared types for the round-robin binary-grant arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_rr_pick.sv
// ============================================================================
// Module : arb_rr_pick
// Brief  : Rotated priority encoder: first request at or above ptr, else wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_rr_pick #(
    parameter int WIDTH      = 8,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req,
    input  logic [WIDTH_LOG-1:0] ptr,
    output logic                 any,
    output logic [WIDTH_LOG-1:0] idx
);

    logic                 w_hit_m;
    logic [WIDTH_LOG-1:0] w_idx_m;
    logic [WIDTH_LOG-1:0] w_idx_u;

    // Descending scan leaves the lowest qualifying index in each result.
    always_comb begin
        w_hit_m = 1'b0;
        w_idx_m = '0;
        w_idx_u = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                w_hit_m = 1'b1;
                w_idx_m = WIDTH_LOG'(i);
            end
            if (req[i]) begin
                w_idx_u = WIDTH_LOG'(i);
            end
        end
    end

    assign any = |req;
    assign idx = w_hit_m ? w_idx_m : w_idx_u;

endmodule

`default_nettype wire

// File: rtl/bin2oht.sv
// ============================================================================
// Module : bin2oht
// Brief  : Binary-to-one-hot decoder with qualifying valid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2oht #(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
    input  logic                 vld,
    input  logic [WIDTH_LOG-1:0] bin,
    output logic [WIDTH-1:0]     oht
);

    generate
        if (IMPLEMENTATION == 0) begin : g_flat
            always_comb begin
                oht = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    oht[i] = vld && (int'(bin) == i);
                end
            end
        end else begin : g_tree
            // Leaf select from the low index bits, group select from the rest.
            always_comb begin
                oht = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    oht[i] = vld && ((int'(bin) % SPLIT) == (i % SPLIT))
                                 && ((int'(bin) / SPLIT) == (i / SPLIT));
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/arb_rr_bin.sv
// ============================================================================
// Module : arb_rr_bin
// Brief  : Round-robin arbiter with held binary grant, release and timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_rr_bin
    import arb_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0,
    parameter int TIMEOUT        = 0,
    localparam int WIDTH_LOG     = $clog2(WIDTH),
    localparam int TMO_LOG       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req,
    input  logic                 ack,
    output logic                 gnt_vld,
    output logic [WIDTH_LOG-1:0] gnt_bin,
    output logic [WIDTH-1:0]     gnt_oht,
    output logic                 tmo
);

    localparam logic [TMO_LOG-1:0]   C_TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_LOG'(TIMEOUT - 1);
    localparam logic [WIDTH_LOG-1:0] C_IDX_LAST = WIDTH_LOG'(WIDTH - 1);

    arb_state_t           r_state, w_nxt_state;
    logic                 r_vld,   w_nxt_vld;
    logic [WIDTH_LOG-1:0] r_bin,   w_nxt_bin;
    logic [WIDTH_LOG-1:0] r_ptr,   w_nxt_ptr;
    logic [TMO_LOG-1:0]   r_cnt,   w_nxt_cnt;
    logic                 r_tmo,   w_nxt_tmo;

    logic                 w_cur_req;
    logic                 w_hit_tmo;
    logic                 w_release;
    logic                 w_any;
    logic [WIDTH_LOG-1:0] w_idx;

    assign w_cur_req = req[r_bin];
    assign w_hit_tmo = (TIMEOUT != 0) && (r_cnt == C_TMO_LAST);
    assign w_release = (r_state == BUSY) && (ack || !w_cur_req || w_hit_tmo);
    assign w_nxt_tmo = (r_state == BUSY) && w_hit_tmo && !ack && w_cur_req;
    assign w_nxt_ptr = !w_release ? r_ptr :
                       (r_bin == C_IDX_LAST) ? '0 : r_bin + 1'b1;

    // A withdrawn requester already shows 0 in req, so no extra masking is needed.
    arb_rr_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .req (req),
        .ptr (w_nxt_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_vld   = r_vld;
        w_nxt_bin   = r_bin;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_nxt_state = BUSY;
                    w_nxt_vld   = 1'b1;
                    w_nxt_bin   = w_idx;
                    w_nxt_cnt   = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_nxt_cnt = '0;
                    if (w_any) begin
                        w_nxt_bin = w_idx;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_vld   = 1'b0;
                        w_nxt_bin   = '0;
                    end
                end else if (r_cnt != '1) begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_vld   = 1'b0;
                w_nxt_bin   = '0;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vld   <= 1'b0;
            r_bin   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_vld   <= w_nxt_vld;
            r_bin   <= w_nxt_bin;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= w_nxt_cnt;
            r_tmo   <= w_nxt_tmo;
        end
    end

    bin2oht #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_bin2oht (
        .vld (r_vld),
        .bin (r_bin),
        .oht (gnt_oht)
    );

    assign gnt_vld = r_vld;
    assign gnt_bin = r_bin;
    assign tmo     = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_arb_rr_bin.sv
// ============================================================================
// Module : tb_arb_rr_bin
// Brief  : Self-checking bench for arb_rr_bin (WIDTH=5, TIMEOUT=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arb_rr_bin;

    localparam int W = 5;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] req = '0;
    logic         ack = 1'b0;
    logic         gnt_vld;
    logic [2:0]   gnt_bin;
    logic [W-1:0] gnt_oht;
    logic         tmo;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state, kept as plain integers.
    int m_ptr = 0;
    int m_bin = 0;
    int m_cnt = 0;
    bit m_vld = 0;
    bit m_tmo = 0;

    always #5 clk = ~clk;

    arb_rr_bin #(
        .WIDTH          (W),
        .SPLIT          (2),
        .IMPLEMENTATION (0),
        .TIMEOUT        (T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .gnt_vld (gnt_vld),
        .gnt_bin (gnt_bin),
        .gnt_oht (gnt_oht),
        .tmo     (tmo)
    );

    function automatic int rr_search(input logic [W-1:0] r, input int from);
        for (int k = 0; k < W; k++) begin
            if (r[(from + k) % W]) return (from + k) % W;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [W-1:0] r, input bit a, input bit rs);
        int w;
        bit still, hit;
        if (rs) begin
            m_ptr = 0; m_bin = 0; m_cnt = 0; m_vld = 0; m_tmo = 0;
        end else if (!m_vld) begin
            m_tmo = 0;
            w = rr_search(r, m_ptr);
            if (w >= 0) begin
                m_vld = 1; m_bin = w; m_cnt = 0;
            end
        end else begin
            still = r[m_bin];
            hit   = (m_cnt == T - 1);
            m_tmo = hit && !a && still;
            if (a || !still || hit) begin
                m_ptr = (m_bin + 1) % W;
                m_cnt = 0;
                w = rr_search(r, m_ptr);
                if (w >= 0) m_bin = w;
                else begin
                    m_vld = 0; m_bin = 0;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    function automatic logic [W+4:0] exp_bus();
        logic [W-1:0] oht;
        oht = m_vld ? W'(1 << m_bin) : '0;
        return {m_vld, 3'(m_bin), oht, m_tmo};
    endfunction

    task automatic step(input logic [W-1:0] r, input bit a, input bit rs);
        req = r; ack = a; rst = rs;
        @(posedge clk);
        model_edge(r, a, rs);
        #1;
    endtask

    task automatic test_reset();
        step(5'b11111, 1'b0, 1'b1);
        step(5'b11111, 1'b0, 1'b1);
        n_cmp++;
        if ({gnt_vld, gnt_oht, tmo} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got vld=%0b oht=%b tmo=%0b, want 0/00000/0", gnt_vld, gnt_oht, tmo);
        end
        step(5'b11111, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_bin !== 3'd0 || gnt_oht !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got vld=%0b bin=%0d oht=%b, want 1/0/00001", gnt_vld, gnt_bin, gnt_oht);
        end
    endtask

    task automatic test_rotation();
        for (int k = 1; k <= 6; k++) begin
            step(5'b11111, 1'b1, 1'b0);
            n_cmp++;
            if (gnt_vld !== 1'b1 || gnt_bin !== 3'(k % W) || {gnt_vld, gnt_bin, gnt_oht, tmo} !== exp_bus()) begin
                n_fail++;
                $display("FAIL rotation_%0d: got vld=%0b bin=%0d, want 1/%0d", k, gnt_vld, gnt_bin, k % W);
            end
        end
    endtask

    task automatic test_withdrawal();
        step(5'b00000, 1'b0, 1'b1);
        step(5'b00100, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_bin !== 3'd2) begin
            n_fail++;
            $display("FAIL withdraw_grant2: got vld=%0b bin=%0d, want 1/2", gnt_vld, gnt_bin);
        end
        step(5'b01000, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_bin !== 3'd3 || gnt_oht !== 5'b01000 || tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_to3: got vld=%0b bin=%0d oht=%b tmo=%0b, want 1/3/01000/0", gnt_vld, gnt_bin, gnt_oht, tmo);
        end
        step(5'b00000, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_vld !== 1'b0 || gnt_bin !== 3'd0 || gnt_oht !== 5'b0) begin
            n_fail++;
            $display("FAIL withdraw_idle: got vld=%0b bin=%0d oht=%b, want 0/0/00000", gnt_vld, gnt_bin, gnt_oht);
        end
        // ptr should now be 4: with 0 and 4 requesting, 4 wins.
        step(5'b10001, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_bin !== 3'd4) begin
            n_fail++;
            $display("FAIL withdraw_ptr: got bin=%0d, want 4", gnt_bin);
        end
    endtask

    task automatic test_timeout();
        step(5'b00000, 1'b0, 1'b1);
        step(5'b00010, 1'b0, 1'b0);
        for (int round = 0; round < 2; round++) begin
            for (int c = 1; c <= T; c++) begin
                step(5'b00010, 1'b0, 1'b0);
                n_cmp++;
                if (tmo !== (c == T) || gnt_vld !== 1'b1 || gnt_bin !== 3'd1) begin
                    n_fail++;
                    $display("FAIL timeout_r%0d_c%0d: got tmo=%0b vld=%0b bin=%0d, want %0b/1/1",
                             round, c, tmo, gnt_vld, gnt_bin, c == T);
                end
            end
        end
    endtask

    task automatic test_simul_release();
        step(5'b00000, 1'b0, 1'b1);
        step(5'b00010, 1'b0, 1'b0);
        for (int c = 0; c < T - 1; c++) step(5'b00010, 1'b0, 1'b0);
        step(5'b00100, 1'b1, 1'b0);
        n_cmp++;
        if (tmo !== 1'b0 || gnt_vld !== 1'b1 || gnt_bin !== 3'd2) begin
            n_fail++;
            $display("FAIL simul_release: got tmo=%0b vld=%0b bin=%0d, want 0/1/2", tmo, gnt_vld, gnt_bin);
        end
        step(5'b11111, 1'b1, 1'b0);
        n_cmp++;
        if (gnt_bin !== 3'd3 || tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_ptr: got bin=%0d tmo=%0b, want 3/0", gnt_bin, tmo);
        end
    endtask

    task automatic test_mid_reset();
        step(5'b00000, 1'b0, 1'b1);
        step(5'b01000, 1'b0, 1'b0);
        step(5'b01000, 1'b1, 1'b1);
        n_cmp++;
        if (gnt_vld !== 1'b0 || gnt_oht !== 5'b0 || tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got vld=%0b oht=%b tmo=%0b, want 0/00000/0", gnt_vld, gnt_oht, tmo);
        end
        step(5'b11000, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_bin !== 3'd3) begin
            n_fail++;
            $display("FAIL midreset_regrant: got vld=%0b bin=%0d, want 1/3", gnt_vld, gnt_bin);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r;
        bit a, rs;
        for (int n = 0; n < 400; n++) begin
            r  = W'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            a  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 49) == 0);
            step(r, a, rs);
            n_cmp++;
            if ({gnt_vld, gnt_bin, gnt_oht, tmo} !== exp_bus()) begin
                n_fail++;
                $display("FAIL random_%0d: got vld=%0b bin=%0d oht=%b tmo=%0b, want %b",
                         n, gnt_vld, gnt_bin, gnt_oht, tmo, exp_bus());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_withdrawal();
        test_timeout();
        test_simul_release();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
